// File: rtl/vending_pkg.sv
// Shared types and defaults for the multi-item vending controller.
package vending_pkg;

  localparam int STATE_W        = 2;
  localparam int DEF_VAL_W      = 8;
  localparam int DEF_MAX_CREDIT = 200;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_e;

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register: ceiling-checked coin add, price subtract and clear,
// plus the combinational coin-reject decision registered by the top.
module vend_credit_acc
  import vending_pkg::*;
#(
  parameter int VAL_W      = DEF_VAL_W,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_en,
  input  logic             coin_block,
  input  logic [VAL_W-1:0] coin_value,
  input  logic             sub_en,
  input  logic [VAL_W-1:0] sub_val,
  input  logic             clr_en,
  output logic [VAL_W-1:0] credit,
  output logic [VAL_W-1:0] credit_nxt,
  output logic             coin_reject_nxt
);

  localparam logic [VAL_W:0] MAX_W = MAX_CREDIT[VAL_W:0];

  logic [VAL_W-1:0] credit_q, credit_d;
  logic [VAL_W:0]   sum;

  always_comb begin
    credit_d        = credit_q;
    coin_reject_nxt = 1'b0;
    // One extra bit on the sum so an oversized coin can never wrap past the check.
    sum             = {1'b0, credit_q} + {1'b0, coin_value};
    if (clr_en) begin
      credit_d = '0;
    end else if (sub_en) begin
      credit_d = credit_q - sub_val;
    end else if (coin_en && coin_value != '0) begin
      if (sum <= MAX_W) credit_d = sum[VAL_W-1:0];
      else              coin_reject_nxt = 1'b1;
    end
    if (coin_block) coin_reject_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) credit_q <= '0;
    else     credit_q <= credit_d;
  end

  assign credit     = credit_q;
  assign credit_nxt = credit_d;

endmodule

// File: rtl/vending_controller.sv
// Multi-item vending controller: FSM, price lookup and registered outputs.
// Change handshake: change_valid/change_amount hold until change_ack is seen in CHANGE.
module vending_controller
  import vending_pkg::*;
#(
  parameter int VAL_W      = DEF_VAL_W,
  parameter int NUM_ITEMS  = 4,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coin_valid,
  input  logic [VAL_W-1:0]             coin_value,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
  input  logic                         cancel,
  input  logic [NUM_ITEMS*VAL_W-1:0]   price_table,
  input  logic                         change_ack,
  output logic [STATE_W-1:0]           state,
  output logic [VAL_W-1:0]             credit,
  output logic                         is_dispensed,
  output logic [$clog2(NUM_ITEMS)-1:0] dispensed_item,
  output logic                         coin_reject,
  output logic                         sel_denied,
  output logic                         change_valid,
  output logic [VAL_W-1:0]             change_amount
);

  localparam int SEL_W = $clog2(NUM_ITEMS);

  state_e           state_q, state_d;
  logic             is_dispensed_q, is_dispensed_d;
  logic [SEL_W-1:0] dispensed_item_q, dispensed_item_d;
  logic             coin_reject_q, coin_reject_d;
  logic             sel_denied_q, sel_denied_d;
  logic             change_valid_q, change_valid_d;
  logic [VAL_W-1:0] change_amount_q, change_amount_d;

  logic             coin_en, coin_block, sub_en, clr_en, grant;
  logic [VAL_W-1:0] sel_price, credit_nxt;

  vend_credit_acc #(.VAL_W(VAL_W), .MAX_CREDIT(MAX_CREDIT)) u_acc (
    .clk             (clk),
    .rst             (rst),
    .coin_en         (coin_en),
    .coin_block      (coin_block),
    .coin_value      (coin_value),
    .sub_en          (sub_en),
    .sub_val         (sel_price),
    .clr_en          (clr_en),
    .credit          (credit),
    .credit_nxt      (credit_nxt),
    .coin_reject_nxt (coin_reject_d)
  );

  // An index beyond the table reads as price 0, which is never granted.
  always_comb begin
    sel_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (int'(sel_item) == i) sel_price = price_table[i*VAL_W +: VAL_W];
    end
  end

  assign grant = sel_valid && (sel_price != '0) && (credit >= sel_price);

  always_comb begin
    state_d          = state_q;
    is_dispensed_d   = 1'b0;
    dispensed_item_d = dispensed_item_q;
    sel_denied_d     = 1'b0;
    change_valid_d   = change_valid_q;
    change_amount_d  = change_amount_q;
    coin_en          = 1'b0;
    coin_block       = 1'b0;
    sub_en           = 1'b0;
    clr_en           = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        if (cancel && state_q == ACCUM) begin
          state_d         = CHANGE;
          change_valid_d  = 1'b1;
          change_amount_d = credit;
          coin_block      = coin_valid;
        end else if (grant) begin
          state_d          = DISPENSE;
          is_dispensed_d   = 1'b1;
          dispensed_item_d = sel_item;
          sub_en           = 1'b1;
          coin_block       = coin_valid;
        end else begin
          sel_denied_d = sel_valid;
          coin_en      = coin_valid;
          state_d      = (credit_nxt != '0) ? ACCUM : IDLE;
        end
      end
      DISPENSE: begin
        coin_block = coin_valid;
        if (credit != '0) begin
          state_d         = CHANGE;
          change_valid_d  = 1'b1;
          change_amount_d = credit;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        coin_block = coin_valid;
        if (change_ack) begin
          clr_en          = 1'b1;
          change_valid_d  = 1'b0;
          change_amount_d = '0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      is_dispensed_q   <= 1'b0;
      dispensed_item_q <= '0;
      coin_reject_q    <= 1'b0;
      sel_denied_q     <= 1'b0;
      change_valid_q   <= 1'b0;
      change_amount_q  <= '0;
    end else begin
      state_q          <= state_d;
      is_dispensed_q   <= is_dispensed_d;
      dispensed_item_q <= dispensed_item_d;
      coin_reject_q    <= coin_reject_d;
      sel_denied_q     <= sel_denied_d;
      change_valid_q   <= change_valid_d;
      change_amount_q  <= change_amount_d;
    end
  end

  assign state          = state_q;
  assign is_dispensed   = is_dispensed_q;
  assign dispensed_item = dispensed_item_q;
  assign coin_reject    = coin_reject_q;
  assign sel_denied     = sel_denied_q;
  assign change_valid   = change_valid_q;
  assign change_amount  = change_amount_q;

endmodule
